tx_uart: RTL and testbench
==========================

// Module: tx_uart
// PURPOSE
//  UART transmitter: serialises one parallel byte per valid/ready handshake onto a single line.
//  Frame order: start bit (0), DATA_BIT data bits LSB first, optional parity, STOP_BIT stop bits (1).
//  Peer of the rx_uart receiver: same frame format and the same bit-period counter semantics.
//  Sits between the user/loopback logic and the board TX pin.
// PARAMETERS
//  DATA_BIT    8     data bits per frame (5..9)
//  STOP_BIT    1     stop bits per frame (1..2)
//  BPS_MAX     9600  clocks per bit period (>=2); the bit counter is 26 bits wide
//  PARITY_ODD  0     0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined
// PORTS
//  clk       in   1         system clock; every register updates on its rising edge
//  rst       in   1         synchronous reset, active-high
//  tx_data   in   DATA_BIT  byte to send; sampled only on the accept cycle
//  tx_valid  in   1         request to send tx_data
//  tx_ready  out  1         block is idle and will accept a request this cycle
//  tx_done   out  1         one-cycle pulse when the last stop bit completes
//  tx        out  1         serial line, registered, idles high
// BEHAVIOUR
//  - Reset: synchronous, active-high; one clk edge with rst=1 resets the block.
//    State=IDLE, tx=1, tx_ready=1, tx_done=0, bit counters=0, shift register=0.
//  - Reset asserted mid-frame: the frame is aborted, state=IDLE and tx=1 on that edge. No tx_done pulse.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - tx_ready = (state==IDLE). It is combinational from state and never depends on tx_valid.
//  - Accept: on an edge where tx_valid && tx_ready:
//    - latch tx_data into the shift register;
//    - state <= START, tx <= 0.
//    The first start-bit clock is the cycle after the accept.
//  - tx_valid while the block is busy is ignored, and tx_data changes while busy have no effect.
//  - Bit timing:
//    - bps_cnt counts 0..BPS_MAX-1 in every state except IDLE; each line level is held exactly BPS_MAX clocks.
//    - bit_cnt advances when bps_cnt wraps and ends at the per-state limit: START=1, DATA=DATA_BIT, PARITY=1, STOP=STOP_BIT.
//  - Data bits: tx driven from shift register bit 0; the register shifts right at each bit boundary (LSB first).
//  - State transitions and tx level changes occur on the same edge where bps_cnt wraps. tx is glitch-free and registered.
//  - Frame length: (1 + DATA_BIT + P + STOP_BIT) * BPS_MAX clocks, where P = 1 with parity and 0 without.
//  - tx_done: pulses high for exactly the one cycle in which STOP -> IDLE occurs.
//  - Back-to-back: if tx_valid is held high, the next accept happens in the first IDLE cycle.
//    Gap between consecutive frames is exactly 1 clock of tx=1 beyond the stop bits.
//  - Counters clear to 0 on leaving IDLE. No arithmetic overflow is possible for BPS_MAX < 2^26.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    - PARITY state is inserted after DATA; tx = (^latched_data) ^ PARITY_ODD for one bit period.
//    - Parity is computed from the byte latched at accept, not from the live tx_data.
//  UART_TX_PARITY_EN undefined:
//    - No PARITY state and no parity logic; DATA -> STOP directly. PARITY_ODD is ignored.
// TESTING (sim with BPS_MAX=4, DATA_BIT=8, STOP_BIT=1)
//  1. Reset:
//     - Stimulus: hold rst=1 for 3 clks, tx_valid=0.
//     - Required: tx=1, tx_ready=1, tx_done=0 throughout and after.
//  2. Single frame, no parity:
//     - Stimulus: tx_data=8'hA5, 1-clk tx_valid.
//     - Required line sequence: 0,1,0,1,0,0,1,0,1,1, each level held 4 clks.
//     - Required: tx_done pulses at clk 40 after accept; tx_ready=0 throughout.
//  3. Back-to-back:
//     - Stimulus: tx_valid held high with 8'h00 then 8'hFF.
//     - Required: second start bit begins 1 clk after the first tx_done; both frames exact.
//  4. Ignored requests and data changes while busy:
//     - Stimulus: pulse tx_valid with 8'h3C mid-frame of 8'h81, and change tx_data during that frame.
//     - Required: only the 8'h81 frame is sent, unchanged.
//  5. Reset mid-frame:
//     - Stimulus: assert rst during data bit 3.
//     - Required: tx=1 and tx_ready=1 on the next edge; no tx_done.
//     - Required: a new 8'h5A then sends cleanly.
//  6. UART_TX_PARITY_EN defined:
//     - 8'hA5 with PARITY_ODD=0 -> parity bit 0; 8'h07 with PARITY_ODD=0 -> parity bit 1.
//     - PARITY_ODD=1 -> both inverted.
//     - Frame length 44 clks.

Source files
------------

// File: rtl/tx_uart.sv
// UART transmitter: start bit, DATA_BIT data bits LSB first, parity bit only when UART_TX_PARITY_EN is defined, STOP_BIT stop bits.
// Latency: line falls on the accept edge; backpressure: tx_ready stays low from accept until the cycle after the last stop bit.
module tx_uart #(
    parameter int DATA_BIT   = 8,
    parameter int STOP_BIT   = 1,
    parameter int BPS_MAX    = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_BIT-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                tx_done,
    output logic                tx
);

    if (DATA_BIT < 5 || DATA_BIT > 9 || STOP_BIT < 1 || STOP_BIT > 2 ||
        BPS_MAX < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("tx_uart: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [25:0] BPS_LAST  = 26'(BPS_MAX - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BIT - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BIT - 1);

    state_t              state_q, state_d;
    logic [25:0]         bps_q, bps_d;
    logic [3:0]          bit_q, bit_d;
    logic [DATA_BIT-1:0] shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic       bps_wrap;
    logic [3:0] bit_last;
    logic       bit_end;

    // bit_end marks the final clock of the last bit belonging to the current state
    assign bps_wrap = (bps_q == BPS_LAST);

    always_comb begin
        bit_last = 4'd0;
        case (state_q)
            S_DATA:  bit_last = DATA_LAST;
            S_STOP:  bit_last = STOP_LAST;
            default: bit_last = 4'd0;
        endcase
    end

    assign bit_end = bps_wrap && (bit_q == bit_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tx_valid) state_d = S_START;
            S_START:  if (bit_end)  state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (bit_end)  state_d = S_PARITY;
            S_PARITY: if (bit_end)  state_d = S_STOP;
`else
            S_DATA:   if (bit_end)  state_d = S_STOP;
`endif
            S_STOP:   if (bit_end)  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bps_d   = bps_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q == S_IDLE || state_d != state_q) begin
            bps_d = 26'd0;
            bit_d = 4'd0;
        end else if (bps_wrap) begin
            bps_d = 26'd0;
            bit_d = bit_q + 4'd1;
        end else begin
            bps_d = bps_q + 26'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d = tx_data;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
`ifdef UART_TX_PARITY_EN
                    tx_d = parity_q;
`else
                    tx_d = 1'b1;
`endif
                end else if (bps_wrap) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) tx_d = 1'b1;
            end
`endif
            S_STOP: begin
                if (bit_end) done_d = 1'b1;
            end
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bps_q   <= 26'd0;
            bit_q   <= 4'd0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            bps_q   <= bps_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx_done  = done_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_tx_uart.sv
// Directed bench for tx_uart with BPS_MAX=4, DATA_BIT=8, STOP_BIT=1.
// Builds with or without UART_TX_PARITY_EN; expected frames come from a bit-level model below.
module tb_tx_uart;

    localparam int BPS  = 4;
    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + DB + PB + SB;
    localparam int FRAME = NBITS * BPS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx;

    int checks = 0;
    int errors = 0;

    tx_uart #(
        .DATA_BIT  (DB),
        .STOP_BIT  (SB),
        .BPS_MAX   (BPS),
        .PARITY_ODD(PODD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done (tx_done),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level for frame bit idx: start, data LSB first, optional parity, stops
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == DB + 1) return (^d) ^ (PODD != 0);
`endif
        return 1'b1;
    endfunction

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("ready_before_send", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    // Starts just after the accept edge; ends just after the edge that raises tx_done
    task automatic check_frame(input logic [7:0] d, input bit disturb);
        for (int c = 1; c <= FRAME; c++) begin
            if (disturb) begin
                if (c == 10) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'h3C;
                end else if (c == 11) begin
                    tx_valid = 1'b0;
                end else if (c == 20) begin
                    tx_data = 8'hFF;
                end
            end
            check($sformatf("line_%02h_c%0d", d, c), {31'd0, tx}, {31'd0, exp_bit(d, (c - 1) / BPS)});
            check($sformatf("busy_ready_%02h_c%0d", d, c), {31'd0, tx_ready}, 32'd0);
            check($sformatf("busy_done_%02h_c%0d", d, c), {31'd0, tx_done}, 32'd0);
            step();
        end
        check($sformatf("done_pulse_%02h", d), {31'd0, tx_done}, 32'd1);
        check($sformatf("gap_line_%02h", d), {31'd0, tx}, 32'd1);
        check($sformatf("idle_ready_%02h", d), {31'd0, tx_ready}, 32'd1);
    endtask

    initial begin
        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tx", {31'd0, tx}, 32'd1);
            check("rst_ready", {31'd0, tx_ready}, 32'd1);
            check("rst_done", {31'd0, tx_done}, 32'd0);
        end
        rst = 1'b0;
        step();
        check("post_rst_tx", {31'd0, tx}, 32'd1);
        check("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        check("post_rst_done", {31'd0, tx_done}, 32'd0);

        // Single frame 8'hA5: 0,1,0,1,0,0,1,0,1,(parity),1
        send(8'hA5);
        check_frame(8'hA5, 1'b0);
        step();
        check("done_one_cycle", {31'd0, tx_done}, 32'd0);
        check("idle_line", {31'd0, tx}, 32'd1);

        // Back-to-back with tx_valid held high
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hFF;
        check_frame(8'h00, 1'b0);
        step();
        tx_valid = 1'b0;
        check("b2b_start_after_gap", {31'd0, tx}, 32'd0);
        check("b2b_done_dropped", {31'd0, tx_done}, 32'd0);
        check_frame(8'hFF, 1'b0);

        // Requests and data changes while busy are ignored
        send(8'h81);
        check_frame(8'h81, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_queued_frame_tx", {31'd0, tx}, 32'd1);
            check("no_queued_frame_ready", {31'd0, tx_ready}, 32'd1);
        end

        // Reset during data bit 3 of 8'hC3
        send(8'hC3);
        for (int i = 0; i < 16; i++) step();
        check("mid_frame_bit3", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_ready", {31'd0, tx_ready}, 32'd1);
        check("abort_done", {31'd0, tx_done}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_done", {31'd0, tx_done}, 32'd0);
            check("abort_idle_tx", {31'd0, tx}, 32'd1);
        end
        send(8'h5A);
        check_frame(8'h5A, 1'b0);

`ifdef UART_TX_PARITY_EN
        // 8'h07 has odd population: even parity bit 1
        send(8'h07);
        for (int i = 0; i < (DB + 1) * BPS; i++) step();
        check("parity_07", {31'd0, tx}, (PODD != 0) ? 32'd0 : 32'd1);
        for (int i = 0; i < 2 * BPS; i++) step();
        check("parity_frame_done", {31'd0, tx_done}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
